i2c_init_seq: RTL and testbench

Parametrised successor to the fixed Si570 init ROM. It walks an external init program (ROM, 1-cycle read latency) and drives the existing i2c_master command and data streams. Unlike the fixed-table block, it adds multi-device addressing, programmable delays, retry on missed ACK and done/error status. It sits beside i2c_master on clk_50mhz and initialises the Si570 and SFP I2C devices.

---
 rtl/i2c_init_pkg.sv | 41 ++++
 rtl/i2c_init_delay.sv | 34 +++
 rtl/i2c_init_seq.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_init_pkg.sv
// i2c_init_pkg: shared definitions for the I2C init-program sequencer.
//   - opcode constants for the 16-bit program entries
//   - entry field bit positions (op in [15:12], arg in [11:0])
//   - sequencer state enum
//   - encode_entry(): builds a program word from opcode and argument
package i2c_init_pkg;

    localparam logic [3:0] OP_END      = 4'd0;
    localparam logic [3:0] OP_SET_ADDR = 4'd1;
    localparam logic [3:0] OP_WRITE    = 4'd2;
    localparam logic [3:0] OP_DELAY    = 4'd3;

    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned ARG_MSB  = 11;
    localparam int unsigned ARG_LSB  = 0;
    localparam int unsigned ADDR_MSB = 6;   // SET_ADDR: arg[6:0]
    localparam int unsigned BYTE_MSB = 7;   // WRITE: arg[7:0]
    localparam int unsigned LAST_BIT = 8;   // WRITE: arg[8]

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_CMD,
        ST_DATA,
        ST_DRAIN,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } state_e;

    function automatic logic [15:0] encode_entry(input logic [3:0] op, input logic [11:0] arg);
        logic [15:0] e;
        e = '0;
        e[OP_MSB:OP_LSB]   = op;
        e[ARG_MSB:ARG_LSB] = arg;
        return e;
    endfunction

endpackage

// File: rtl/i2c_init_delay.sv
// i2c_init_delay: loadable down-counter used for programmable waits.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : load load_val_i (takes priority over dec_i)
//   load_val_i    : W-bit load value
//   dec_i         : decrement by one while non-zero
//   zero_o        : counter is zero
module i2c_init_delay #(
    parameter int unsigned W = 22
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_init_seq.sv
// i2c_init_seq: walks an external init program (1-cycle-latency ROM) and
// drives the i2c_master command / write-data streams.
//   clk, rst               : clock, synchronous active-high reset
//   start                  : begin program (accepted in IDLE/DONE/ERROR)
//   rom_addr / rom_data    : program fetch (data valid one cycle after addr)
//   cmd_*                  : command stream to i2c_master (valid/ready)
//   data_out*              : write-data stream to i2c_master (valid/ready)
//   missed_ack, bus_busy   : status from i2c_master
//   busy, done, error      : sequencer status (done/error sticky until start)
//   fail_pc                : pc of the SET_ADDR entry whose retries ran out
module i2c_init_seq
    import i2c_init_pkg::*;
#(
    parameter int unsigned ROM_AW      = 8,
    parameter int unsigned DELAY_SHIFT = 10,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [6:0]        cmd_address,
    output logic              cmd_start,
    output logic              cmd_read,
    output logic              cmd_write,
    output logic              cmd_write_multiple,
    output logic              cmd_stop,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        data_out,
    output logic              data_out_last,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    input  logic              missed_ack,
    input  logic              bus_busy,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] fail_pc
);

    localparam int unsigned       DW        = 12 + DELAY_SHIFT;
    localparam logic [ROM_AW-1:0] PC_ONE    = 1;
    localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] pc_q, pc_d;
    logic [ROM_AW-1:0] mark_pc_q, mark_pc_d;
    logic [ROM_AW-1:0] fail_pc_q, fail_pc_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic              last_q, last_d;
    logic              hold_pc_q, hold_pc_d;     // forced guard beat: do not advance pc
    logic              in_txn_q, in_txn_d;
    logic              end_q, end_d;             // DRAIN was entered from END
    logic [3:0]        retry_q, retry_d;
    logic              retry_pend_q, retry_pend_d;
    logic              miss_q, miss_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [3:0]        op;
    logic [11:0]       arg;
    logic [DW-1:0]     dly_val;
    logic              dly_load;
    logic              dly_zero;
    logic              busy_w;
    logic              miss_any;

    assign op       = rom_data[OP_MSB:OP_LSB];
    assign arg      = rom_data[ARG_MSB:ARG_LSB];
    assign dly_val  = DW'(arg) << DELAY_SHIFT;
    assign busy_w   = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign miss_any = miss_q | missed_ack;

    i2c_init_delay #(
        .W (DW)
    ) u_delay (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (dly_load),
        .load_val_i (dly_val),
        .dec_i      (state_q == ST_DELAY),
        .zero_o     (dly_zero)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            mark_pc_q    <= '0;
            fail_pc_q    <= '0;
            addr_q       <= '0;
            byte_q       <= '0;
            last_q       <= 1'b0;
            hold_pc_q    <= 1'b0;
            in_txn_q     <= 1'b0;
            end_q        <= 1'b0;
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
            miss_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mark_pc_q    <= mark_pc_d;
            fail_pc_q    <= fail_pc_d;
            addr_q       <= addr_d;
            byte_q       <= byte_d;
            last_q       <= last_d;
            hold_pc_q    <= hold_pc_d;
            in_txn_q     <= in_txn_d;
            end_q        <= end_d;
            retry_q      <= retry_d;
            retry_pend_q <= retry_pend_d;
            miss_q       <= miss_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mark_pc_d    = mark_pc_q;
        fail_pc_d    = fail_pc_q;
        addr_d       = addr_q;
        byte_d       = byte_q;
        last_d       = last_q;
        hold_pc_d    = hold_pc_q;
        in_txn_d     = in_txn_q;
        end_d        = end_q;
        retry_d      = retry_q;
        retry_pend_d = retry_pend_q;
        miss_d       = miss_q | (missed_ack & busy_w);
        done_d       = done_q;
        error_d      = error_q;
        dly_load     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    pc_d         = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    retry_d      = '0;
                    retry_pend_d = 1'b0;
                    in_txn_d     = 1'b0;
                    end_d        = 1'b0;
                    miss_d       = 1'b0;
                end
            end

            ST_FETCH: state_d = ST_DECODE;

            ST_DECODE: begin
                case (op)
                    OP_SET_ADDR, OP_END: begin
                        if (in_txn_q) begin
                            // Unterminated write: close it with a 0x00 last beat,
                            // then re-fetch this same entry.
                            byte_d    = '0;
                            last_d    = 1'b1;
                            hold_pc_d = 1'b1;
                            state_d   = ST_DATA;
                        end else if (op == OP_SET_ADDR) begin
                            addr_d    = arg[ADDR_MSB:0];
                            mark_pc_d = pc_q;
                            pc_d      = pc_q + PC_ONE;
                            // A retry re-enters here; keep its count in that case.
                            if (!retry_pend_q) begin
                                retry_d = '0;
                            end
                            retry_pend_d = 1'b0;
                            state_d      = ST_FETCH;
                        end else begin
                            end_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end
                    OP_WRITE: begin
                        byte_d    = arg[BYTE_MSB:0];
                        last_d    = arg[LAST_BIT];
                        hold_pc_d = 1'b0;
                        if (!in_txn_q) begin
                            in_txn_d = 1'b1;
                            state_d  = ST_CMD;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                    OP_DELAY: begin
                        dly_load = 1'b1;
                        state_d  = ST_DELAY;
                    end
                    default: begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = ST_FETCH;
                    end
                endcase
            end

            ST_CMD: begin
                if (cmd_ready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (data_out_ready) begin
                    if (!hold_pc_q) begin
                        pc_d = pc_q + PC_ONE;
                    end
                    hold_pc_d = 1'b0;
                    if (last_q) begin
                        in_txn_d = 1'b0;
                        state_d  = ST_DRAIN;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_DRAIN: begin
                if (!bus_busy) begin
                    miss_d = 1'b0;
                    if (miss_any) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d      = retry_q + 4'd1;
                            retry_pend_d = 1'b1;
                            pc_d         = mark_pc_q;
                            in_txn_d     = 1'b0;
                            end_d        = 1'b0;
                            state_d      = ST_FETCH;
                        end else begin
                            error_d   = 1'b1;
                            fail_pc_d = mark_pc_q;
                            state_d   = ST_ERROR;
                        end
                    end else if (end_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_DELAY: begin
                if (dly_zero) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_FETCH;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        rom_addr           = pc_q;
        cmd_valid          = (state_q == ST_CMD);
        cmd_address        = cmd_valid ? addr_q : '0;
        cmd_start          = cmd_valid;
        cmd_read           = 1'b0;
        cmd_write          = 1'b0;
        cmd_write_multiple = cmd_valid;
        cmd_stop           = cmd_valid;
        data_out_valid     = (state_q == ST_DATA);
        data_out           = data_out_valid ? byte_q : '0;
        data_out_last      = data_out_valid & last_q;
        busy               = busy_w;
        done               = done_q;
        error              = error_q;
        fail_pc            = fail_pc_q;
    end

endmodule

// File: tb/tb_i2c_init_seq.sv
module tb_i2c_init_seq;
    import i2c_init_pkg::*;

    localparam int unsigned ROM_AW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [6:0]        cmd_address;
    logic              cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
    logic              cmd_valid, cmd_ready;
    logic [7:0]        data_out;
    logic              data_out_last, data_out_valid, data_out_ready;
    logic              missed_ack;
    logic              bus_busy;
    logic              busy, done, error;
    logic [ROM_AW-1:0] fail_pc;

    logic              cmd_rdy_en;
    logic              data_rdy_en;
    int                miss_limit;   // inject missed_ack on beat 2 of commands 1..miss_limit

    logic [15:0]       rom [0:255];
    logic [11:0]       cmd_log [$];  // {start,read,write,wm,stop,addr}
    logic [8:0]        data_log [$]; // {last,byte}
    int                cmd_cyc [$];
    int                last_cyc [$];
    int                cyc = 0;
    int                beat;
    int                busy_cnt;

    int                n_pass = 0;
    int                n_total = 0;

    assign cmd_ready      = cmd_rdy_en;
    assign data_out_ready = data_rdy_en;

    always #5 clk = ~clk;

    i2c_init_seq #(
        .ROM_AW      (ROM_AW),
        .DELAY_SHIFT (2),
        .MAX_RETRY   (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .rom_addr           (rom_addr),
        .rom_data           (rom_data),
        .cmd_address        (cmd_address),
        .cmd_start          (cmd_start),
        .cmd_read           (cmd_read),
        .cmd_write          (cmd_write),
        .cmd_write_multiple (cmd_write_multiple),
        .cmd_stop           (cmd_stop),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .data_out           (data_out),
        .data_out_last      (data_out_last),
        .data_out_valid     (data_out_valid),
        .data_out_ready     (data_out_ready),
        .missed_ack         (missed_ack),
        .bus_busy           (bus_busy),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .fail_pc            (fail_pc)
    );

    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        cyc      <= cyc + 1;
    end

    // i2c_master stand-in: logs handshakes, models bus_busy and missed_ack
    always @(negedge clk) begin
        if (rst) begin
            bus_busy   = 1'b0;
            missed_ack = 1'b0;
            busy_cnt   = 0;
            beat       = 0;
        end else begin
            missed_ack = 1'b0;
            if (cmd_valid && cmd_ready) begin
                cmd_log.push_back({cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_address});
                cmd_cyc.push_back(cyc);
                bus_busy = 1'b1;
                beat     = 0;
                busy_cnt = 0;
            end
            if (data_out_valid && data_out_ready) begin
                data_log.push_back({data_out_last, data_out});
                beat = beat + 1;
                if (beat == 2 && cmd_log.size() <= miss_limit) missed_ack = 1'b1;
                if (data_out_last) begin
                    busy_cnt = 3;
                    last_cyc.push_back(cyc);
                end
            end else if (busy_cnt != 0) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) bus_busy = 1'b0;
            end
        end
    end

    task automatic clear_all;
        cmd_log.delete();
        data_log.delete();
        cmd_cyc.delete();
        last_cyc.delete();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic pulse_start;
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input bit is_data, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((is_data && data_out_valid) || (!is_data && cmd_valid)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_basic;
        rom[0] = encode_entry(OP_SET_ADDR, 12'h055);
        rom[1] = encode_entry(OP_WRITE,    12'h007);
        rom[2] = encode_entry(OP_WRITE,    12'h001);
        rom[3] = encode_entry(OP_WRITE,    12'h1A0);
        rom[4] = encode_entry(OP_END,      12'h000);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_total++;
        if ({busy, done, error, cmd_valid, data_out_valid} !== 5'b0)
            $display("FAIL reset_status: got %b want 00000", {busy, done, error, cmd_valid, data_out_valid});
        else n_pass++;
        n_total++;
        if (rom_addr !== 8'h00) $display("FAIL reset_rom_addr: got %h want 00", rom_addr);
        else n_pass++;
        n_total++;
        if (fail_pc !== 8'h00) $display("FAIL reset_fail_pc: got %h want 00", fail_pc);
        else n_pass++;
    endtask

    task automatic test_basic;
        bit ok;
        logic [11:0] exp_cmd;
        clear_all();
        load_basic();
        pulse_start();
        wait_end(ok);
        exp_cmd = {5'b10011, 7'h55};
        n_total++;
        if (!ok) $display("FAIL basic_timeout: got no done/error want done");
        else n_pass++;
        n_total++;
        if (cmd_log.size() != 1 || cmd_log[0] !== exp_cmd)
            $display("FAIL basic_cmd: got n=%0d first=%h want n=1 first=%h", cmd_log.size(), cmd_log[0], exp_cmd);
        else n_pass++;
        n_total++;
        if (data_log.size() != 3 || data_log[0] !== 9'h007 || data_log[1] !== 9'h001 || data_log[2] !== 9'h1A0)
            $display("FAIL basic_data: got n=%0d %h %h %h want n=3 007 001 1a0",
                     data_log.size(), data_log[0], data_log[1], data_log[2]);
        else n_pass++;
        n_total++;
        if ({done, error, busy} !== 3'b100) $display("FAIL basic_status: got %b want 100", {done, error, busy});
        else n_pass++;
    endtask

    task automatic test_retry_once;
        bit ok;
        clear_all();
        load_basic();
        miss_limit = 1;
        pulse_start();
        wait_end(ok);
        miss_limit = 0;
        n_total++;
        if (!ok) $display("FAIL retry1_timeout: got no done/error want done");
        else n_pass++;
        n_total++;
        if (cmd_log.size() != 2 || cmd_log[1] !== {5'b10011, 7'h55})
            $display("FAIL retry1_cmds: got n=%0d second=%h want n=2 second=9d5", cmd_log.size(), cmd_log[1]);
        else n_pass++;
        n_total++;
        if (data_log.size() != 6 || data_log[3] !== 9'h007 || data_log[5] !== 9'h1A0)
            $display("FAIL retry1_data: got n=%0d [3]=%h [5]=%h want n=6 007 1a0",
                     data_log.size(), data_log[3], data_log[5]);
        else n_pass++;
        n_total++;
        if ({done, error} !== 2'b10) $display("FAIL retry1_status: got %b want 10", {done, error});
        else n_pass++;
    endtask

    task automatic test_retry_exhaust;
        bit ok;
        // first the plain program at pc 0
        clear_all();
        load_basic();
        miss_limit = 100;
        pulse_start();
        wait_end(ok);
        n_total++;
        if (!ok || cmd_log.size() != 4)
            $display("FAIL exhaust0_cmds: got ok=%0d n=%0d want ok=1 n=4", ok, cmd_log.size());
        else n_pass++;
        n_total++;
        if ({done, error, busy} !== 3'b010 || fail_pc !== 8'h00)
            $display("FAIL exhaust0_status: got dne/err/bsy=%b fail_pc=%h want 010 00", {done, error, busy}, fail_pc);
        else n_pass++;
        // retry point not at pc 0, preceded by a NOP entry
        clear_all();
        rom[0] = encode_entry(4'hF,        12'h000);
        rom[1] = encode_entry(OP_SET_ADDR, 12'h021);
        rom[2] = encode_entry(OP_WRITE,    12'h033);
        rom[3] = encode_entry(OP_WRITE,    12'h144);
        rom[4] = encode_entry(OP_END,      12'h000);
        pulse_start();
        wait_end(ok);
        miss_limit = 0;
        n_total++;
        if (!ok || cmd_log.size() != 4 || cmd_log[3] !== {5'b10011, 7'h21} || data_log.size() != 8)
            $display("FAIL exhaust1_cmds: got ok=%0d n=%0d last=%h beats=%0d want ok=1 n=4 last=9a1 beats=8",
                     ok, cmd_log.size(), cmd_log[3], data_log.size());
        else n_pass++;
        n_total++;
        if ({done, error} !== 2'b01 || fail_pc !== 8'h01)
            $display("FAIL exhaust1_status: got dne/err=%b fail_pc=%h want 01 01", {done, error}, fail_pc);
        else n_pass++;
    endtask

    task automatic run_delay_prog(input logic [11:0] darg, output int gap, output bit ok);
        clear_all();
        rom[0] = encode_entry(OP_SET_ADDR, 12'h010);
        rom[1] = encode_entry(OP_WRITE,    12'h111);
        rom[2] = encode_entry(OP_DELAY,    darg);
        rom[3] = encode_entry(OP_SET_ADDR, 12'h020);
        rom[4] = encode_entry(OP_WRITE,    12'h122);
        rom[5] = encode_entry(OP_END,      12'h000);
        pulse_start();
        wait_end(ok);
        gap = (cmd_cyc.size() >= 2 && last_cyc.size() >= 1) ? cmd_cyc[1] - last_cyc[0] : -1;
        ok = ok && done && cmd_log.size() == 2 && cmd_log[1] === {5'b10011, 7'h20} && data_log.size() == 2;
    endtask

    task automatic test_delay;
        int gap0, gap3;
        bit ok0, ok3;
        run_delay_prog(12'd0, gap0, ok0);
        run_delay_prog(12'd3, gap3, ok3);
        n_total++;
        if (!ok0 || !ok3) $display("FAIL delay_run: got ok0=%0d ok3=%0d want 1 1", ok0, ok3);
        else n_pass++;
        n_total++;
        if (gap3 - gap0 != 12) $display("FAIL delay_gap: got %0d (gap0=%0d gap3=%0d) want 12", gap3 - gap0, gap0, gap3);
        else n_pass++;
    endtask

    task automatic test_stall;
        bit ok;
        clear_all();
        load_basic();
        @(posedge clk) #1;
        cmd_rdy_en  = 1'b0;
        data_rdy_en = 1'b0;
        pulse_start();
        wait_valid(1'b0, ok);
        n_total++;
        if (!ok) $display("FAIL stall_cmd_wait: got no cmd_valid want cmd_valid");
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) start = 1'b1;
            if (i == 11) start = 1'b0;
            n_total++;
            if ({cmd_valid, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_address} !== {6'b110011, 7'h55})
                $display("FAIL stall_cmd_hold: got %h want %h",
                         {cmd_valid, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_address},
                         {6'b110011, 7'h55});
            else n_pass++;
        end
        @(posedge clk) #1 cmd_rdy_en = 1'b1;
        wait_valid(1'b1, ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) start = 1'b1;
            if (i == 6) start = 1'b0;
            n_total++;
            if ({data_out_valid, data_out_last, data_out, busy} !== {2'b10, 8'h07, 1'b1})
                $display("FAIL stall_data_hold: got %h want %h",
                         {data_out_valid, data_out_last, data_out, busy}, {2'b10, 8'h07, 1'b1});
            else n_pass++;
        end
        @(posedge clk) #1 data_rdy_en = 1'b1;
        wait_end(ok);
        n_total++;
        if (!ok || !done || cmd_log.size() != 1 || data_log.size() != 3 || data_log[2] !== 9'h1A0)
            $display("FAIL stall_result: got ok=%0d done=%0d cmds=%0d beats=%0d want 1 1 1 3",
                     ok, done, cmd_log.size(), data_log.size());
        else n_pass++;
    endtask

    task automatic test_rst_mid;
        bit ok;
        clear_all();
        load_basic();
        @(posedge clk) #1 data_rdy_en = 1'b0;
        pulse_start();
        wait_valid(1'b1, ok);
        n_total++;
        if (!ok) $display("FAIL rstmid_wait: got no data_out_valid want data_out_valid");
        else n_pass++;
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1;
        n_total++;
        if ({busy, data_out_valid, data_out_last, data_out, cmd_valid, done, error, rom_addr} !== '0)
            $display("FAIL rstmid_outputs: got %h want 0",
                     {busy, data_out_valid, data_out_last, data_out, cmd_valid, done, error, rom_addr});
        else n_pass++;
        rst         = 1'b0;
        data_rdy_en = 1'b1;
        clear_all();
        load_basic();
        pulse_start();
        wait_end(ok);
        n_total++;
        if (!ok || !done || cmd_log.size() != 1 || data_log.size() != 3 || data_log[0] !== 9'h007)
            $display("FAIL rstmid_rerun: got ok=%0d done=%0d cmds=%0d beats=%0d first=%h want 1 1 1 3 007",
                     ok, done, cmd_log.size(), data_log.size(), data_log[0]);
        else n_pass++;
    endtask

    task automatic test_guard;
        bit ok;
        clear_all();
        rom[0] = encode_entry(OP_SET_ADDR, 12'h030);
        rom[1] = encode_entry(OP_WRITE,    12'h044);
        rom[2] = encode_entry(OP_SET_ADDR, 12'h031);
        rom[3] = encode_entry(OP_WRITE,    12'h155);
        rom[4] = encode_entry(OP_END,      12'h000);
        pulse_start();
        wait_end(ok);
        n_total++;
        if (!ok || cmd_log.size() != 2 || cmd_log[0][6:0] !== 7'h30 || cmd_log[1][6:0] !== 7'h31)
            $display("FAIL guard_cmds: got ok=%0d n=%0d %h %h want 1 2 0x30 0x31",
                     ok, cmd_log.size(), cmd_log[0], cmd_log[1]);
        else n_pass++;
        n_total++;
        if (data_log.size() != 3 || data_log[0] !== 9'h044 || data_log[1] !== 9'h100 || data_log[2] !== 9'h155)
            $display("FAIL guard_data: got n=%0d %h %h %h want 3 044 100 155",
                     data_log.size(), data_log[0], data_log[1], data_log[2]);
        else n_pass++;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        cmd_rdy_en  = 1'b1;
        data_rdy_en = 1'b1;
        miss_limit  = 0;
        clear_all();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(posedge clk) #1 rst = 1'b0;
        test_basic();
        test_retry_once();
        test_retry_exhaust();
        test_delay();
        test_stall();
        test_rst_mid();
        test_guard();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
